// File: rtl/hex_display_ctrl.sv
// Multi-digit hex seven-segment controller: serial digit conversion
// through one shared decoder, atomic commit, per-digit blink.
//
// Ports:
//   clock    - sole clock, rising edge
//   reset    - synchronous, active-high
//   value    - DIGITS hex nibbles, digit 0 least significant
//   load     - capture request, honoured only while busy is low
//   lz_sup   - leading-zero suppression, captured with value
//   blink_en - per-digit blink mask, sampled every cycle
//   busy     - conversion in progress
//   seg      - registered active-low segments, 7 bits per digit (a..g)
module hex_display_ctrl #(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  lz_sup,
    input  logic [DIGITS-1:0]     blink_en,
    output logic                  busy,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(BLINK_DIV - 1);
    localparam logic [6:0]    BLANK   = 7'h7F;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_e;

    state_e state_q, state_d;

    logic [4*DIGITS-1:0] val_q, val_d;
    logic                lz_q, lz_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                zrun_q, zrun_d;
    logic [7*DIGITS-1:0] shadow_q, shadow_d;
    logic [7*DIGITS-1:0] commit_q, commit_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                phase_q, phase_d;

    logic                accept;
    logic                last;
    logic [3:0]          nib;
    logic [6:0]          pat;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (load) state_d = S_CONV;
            S_CONV: if (idx_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = (state_q == S_CONV);
        accept = (state_q == S_IDLE) && load;
        last   = (state_q == S_CONV) && (idx_q == '0);
    end

    // Shared decoder; digit 0 is exempt from suppression so that
    // an all-zero value still shows a single "0".
    always_comb begin
        nib = val_q[idx_q*4 +: 4];
        if (lz_q && zrun_q && (nib == 4'h0) && (idx_q != '0)) begin
            pat = BLANK;
        end else begin
            pat = hex7(nib);
        end
    end

    // Conversion datapath
    always_comb begin
        val_d    = val_q;
        lz_d     = lz_q;
        idx_d    = idx_q;
        zrun_d   = zrun_q;
        shadow_d = shadow_q;
        commit_d = commit_q;
        if (accept) begin
            val_d  = value;
            lz_d   = lz_sup;
            idx_d  = IDX_TOP;
            zrun_d = 1'b1;
        end
        if (busy) begin
            shadow_d[idx_q*7 +: 7] = pat;
            if (nib != 4'h0) zrun_d = 1'b0;
            if (idx_q != '0) begin
                idx_d = idx_q - IW'(1);
            end else begin
                idx_d = IDX_TOP;
            end
        end
        // Commit includes the digit decoded this cycle.
        if (last) commit_d = shadow_d;
    end

    // Blink timebase; phase_q high means digits are shown.
    always_comb begin
        if (cnt_q == CNT_TOP) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CW'(1);
            phase_d = phase_q;
        end
    end

    always_comb begin
        seg_d = commit_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (blink_en[i] && !phase_q) seg_d[i*7 +: 7] = BLANK;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            val_q    <= '0;
            lz_q     <= 1'b0;
            idx_q    <= IDX_TOP;
            zrun_q   <= 1'b1;
            shadow_q <= '1;
            commit_q <= '1;
            seg_q    <= '1;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else begin
            val_q    <= val_d;
            lz_q     <= lz_d;
            idx_q    <= idx_d;
            zrun_q   <= zrun_d;
            shadow_q <= shadow_d;
            commit_q <= commit_d;
            seg_q    <= seg_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign seg = seg_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: directed scenarios plus random loads
// checked against an arithmetic model of the display rules.
module tb_hex_display_ctrl;

    logic        clock;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        lz_sup;
    logic [3:0]  blink_en;
    logic        busy;
    logic [27:0] seg;

    int nchk;
    int npass;
    int k;
    logic [27:0] disp;
    logic [6:0]  tbl [16];

    hex_display_ctrl #(
        .DIGITS(4),
        .BLINK_DIV(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .value(value),
        .load(load),
        .lz_sup(lz_sup),
        .blink_en(blink_en),
        .busy(busy),
        .seg(seg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [27:0] model(input logic [15:0] v,
                                          input logic lz);
        int top;
        logic [27:0] r;
        logic [3:0] n;
        top = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] != 4'h0) top = i;
        end
        r = '0;
        for (int i = 0; i < 4; i++) begin
            n = v[4*i +: 4];
            r[7*i +: 7] = (lz && i > top) ? 7'h7F : tbl[n];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        k++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        k = 0;
        reset = 1'b0;
    endtask

    // Runs one conversion and checks busy timing, the unchanged display
    // on the commit cycle, and the new display one cycle later.
    task automatic run_load(input logic [15:0] v, input logic lz,
                            input bit pre, input bit chain,
                            input logic [15:0] nv, input logic nlz);
        logic [27:0] exp;
        exp = model(v, lz);
        if (!pre) begin
            value  = v;
            lz_sup = lz;
            load   = 1'b1;
            step();
            load = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            check("busy_conv", 32'(busy), 32'd1);
            value  = 16'($urandom);
            lz_sup = 1'($urandom);
            step();
        end
        check("busy_done", 32'(busy), 32'd0);
        check("seg_hold", 32'(seg), 32'(disp));
        if (chain) begin
            value  = nv;
            lz_sup = nlz;
            load   = 1'b1;
        end
        step();
        load = 1'b0;
        check("seg_new", 32'(seg), 32'(exp));
        if (chain) check("busy_b2b", 32'(busy), 32'd1);
        disp = exp;
    endtask

    initial begin
        logic ph;
        logic [15:0] rv;
        logic rl;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        nchk     = 0;
        npass    = 0;
        k        = 0;
        reset    = 1'b0;
        load     = 1'b0;
        value    = '0;
        lz_sup   = 1'b0;
        blink_en = '0;

        do_reset();
        check("rst_seg", 32'(seg), 32'h0FFF_FFFF);
        check("rst_busy", 32'(busy), 32'd0);
        step();
        check("rst_blank", 32'(seg), 32'h0FFF_FFFF);
        disp = 28'hFFF_FFFF;

        run_load(16'h12AF, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("r028", 32'(seg), 32'({7'h79, 7'h24, 7'h08, 7'h0E}));

        run_load(16'h0050, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        check("lz_0050", 32'(seg), 32'({7'h7F, 7'h7F, 7'h12, 7'h40}));
        run_load(16'h0000, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        check("lz_0000", 32'(seg), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

        // second load arrives on the second busy cycle and is dropped
        value  = 16'h1111;
        lz_sup = 1'b0;
        load   = 1'b1;
        step();
        load = 1'b0;
        step();
        value = 16'h2222;
        load  = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        check("ign_busy", 32'(busy), 32'd0);
        step();
        check("ign_seg", 32'(seg), 32'({4{7'h79}}));
        step();
        check("ign_noq", 32'(busy), 32'd0);
        disp = seg;

        // back-to-back: load in first idle cycle after commit
        run_load(16'hA5C3, 1'b0, 1'b0, 1'b1, 16'h0F00, 1'b1);
        run_load(16'h0F00, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        check("b2b_seg", 32'(seg), 32'({7'h7F, 7'h0E, 7'h40, 7'h40}));

        // reset mid-conversion, coincident with a load
        value  = 16'hFFFF;
        lz_sup = 1'b0;
        load   = 1'b1;
        step();
        load = 1'b0;
        step();
        check("abort_busy_pre", 32'(busy), 32'd1);
        value = 16'h1234;
        load  = 1'b1;
        do_reset();
        load = 1'b0;
        check("abort_seg", 32'(seg), 32'h0FFF_FFFF);
        check("abort_busy", 32'(busy), 32'd0);
        step();
        check("abort_nocommit", 32'(seg), 32'h0FFF_FFFF);
        check("abort_idle", 32'(busy), 32'd0);
        disp = 28'hFFF_FFFF;
        run_load(16'h8888, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("r032", 32'(seg), 32'd0);

        // blink on digit 0 only, half-period 4 cycles
        run_load(16'h1234, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        blink_en = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            step();
            ph = (((k - 1) / 4) % 2) == 0;
            check("blink_d0", 32'(seg[6:0]), ph ? 32'h19 : 32'h7F);
            check("blink_hi", 32'(seg[27:7]),
                  32'({7'h79, 7'h24, 7'h30}));
        end
        blink_en = 4'b0000;
        step();
        check("blink_off", 32'(seg), 32'(disp));

        // random loads
        for (int r = 0; r < 16; r++) begin
            rv = 16'($urandom);
            if (r % 4 == 0) rv = rv & 16'h00FF;
            rl = 1'($urandom);
            run_load(rv, rl, 1'b0, 1'b0, '0, 1'b0);
            step();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
